// File: rtl/wb_burst_bridge_if.sv
// Wishbone bus bundle used on both sides of wb_burst_bridge.
//
// Signals are named from the bus master's point of view:
//   cyc, stb    cycle / strobe               (master -> slave)
//   adr         address, ADDR_W              (master -> slave)
//   o_dat       write data, DATA_W           (master -> slave)
//   i_dat       read data, DATA_W            (slave -> master)
//   we          write enable                 (master -> slave)
//   sel         byte select, DATA_W/8        (master -> slave)
//   burst_8     8-beat read burst request    (master -> slave)
//   burst_4     4-beat read burst request    (master -> slave)
//   ack, err    per-beat ack / error         (slave -> master)
//
// Modports: master (drives the request), slave (answers it).
interface wb_burst_bridge_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic                  cyc;
  logic                  stb;
  logic [ADDR_W-1:0]     adr;
  logic [DATA_W-1:0]     o_dat;
  logic [DATA_W-1:0]     i_dat;
  logic                  we;
  logic [DATA_W/8-1:0]   sel;
  logic                  burst_8;
  logic                  burst_4;
  logic                  ack;
  logic                  err;

  modport master (
    output cyc, stb, adr, o_dat, we, sel, burst_8, burst_4,
    input  i_dat, ack, err
  );

  modport slave (
    input  cyc, stb, adr, o_dat, we, sel, burst_8, burst_4,
    output i_dat, ack, err
  );
endinterface

// File: rtl/wb_burst_bridge.sv
// wb_burst_bridge: single-clock registered Wishbone slice between a bus
// master and a slave. Every output is registered, so no combinational path
// crosses the bridge. Supports single transfers and 4/8-beat read bursts with
// per-beat ack/err forwarding, error abort and abort when the master drops cyc.
//
// Ports:
//   i_clk   clock, all logic on posedge
//   i_rst   synchronous active-high reset
//   m_wb    bus from the upstream master (slave modport)
//   s_wb    bus to the downstream slave  (master modport)
//
// Optional feature macro: WB_BRIDGE_TIMEOUT_EN
//   When defined, a request that sees no slave ack/err for TIMEOUT_CYC cycles
//   is terminated with an error pulse to the master.
module wb_burst_bridge #(
  parameter int ADDR_W        = 24,
  parameter int DATA_W        = 16,
  parameter int MAX_BURST_LOG = 4,
  parameter int TIMEOUT_CYC   = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  wb_burst_bridge_if.slave  m_wb,
  wb_burst_bridge_if.master s_wb
);

  localparam int SEL_W = DATA_W / 8;

  // Elaboration-time parameter sanity.
  if (MAX_BURST_LOG < 4) begin : g_bad_burst_log
    $error("MAX_BURST_LOG must be wide enough to hold 8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                   state_q;
  logic [MAX_BURST_LOG-1:0] beats_q;

  logic                     s_cyc_q;
  logic                     s_stb_q;
  logic [ADDR_W-1:0]        s_adr_q;
  logic [DATA_W-1:0]        s_dat_q;
  logic                     s_we_q;
  logic [SEL_W-1:0]         s_sel_q;
  logic                     s_b8_q;
  logic                     s_b4_q;

  logic                     m_ack_q;
  logic                     m_err_q;
  logic [DATA_W-1:0]        m_dat_q;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]         tmo_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      beats_q <= '0;
      s_cyc_q <= 1'b0;
      s_stb_q <= 1'b0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      s_we_q  <= 1'b0;
      s_sel_q <= '0;
      s_b8_q  <= 1'b0;
      s_b4_q  <= 1'b0;
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
      m_dat_q <= '0;
`ifdef WB_BRIDGE_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      // ack/err toward the master are one-cycle pulses.
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;

      unique case (state_q)
        // Accept a new request and capture it for the slave side.
        IDLE: begin
          if (m_wb.cyc && m_wb.stb) begin
            s_adr_q <= m_wb.adr;
            s_dat_q <= m_wb.o_dat;
            s_we_q  <= m_wb.we;
            s_sel_q <= m_wb.sel;
            s_b8_q  <= m_wb.burst_8;
            s_b4_q  <= m_wb.burst_4;
            // Writes are single-beat even if a burst flag is set.
            if (m_wb.we)            beats_q <= MAX_BURST_LOG'(1);
            else if (m_wb.burst_8)  beats_q <= MAX_BURST_LOG'(8);
            else if (m_wb.burst_4)  beats_q <= MAX_BURST_LOG'(4);
            else                    beats_q <= MAX_BURST_LOG'(1);
            s_cyc_q <= 1'b1;
            s_stb_q <= 1'b1;
            state_q <= REQ;
`ifdef WB_BRIDGE_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end

        // Request outstanding: forward beats until done, error or abort.
        REQ: begin
          if (!m_wb.cyc) begin
            // Master walked away: drop silently, any same-cycle ack is lost.
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            beats_q <= '0;
            state_q <= IDLE;
          end else if (s_wb.err) begin
            // err takes priority over a simultaneous ack.
            m_err_q <= 1'b1;
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            beats_q <= '0;
            state_q <= RESP;
          end else if (s_wb.ack) begin
            m_ack_q <= 1'b1;
            m_dat_q <= s_wb.i_dat;
            beats_q <= beats_q - 1'b1;
`ifdef WB_BRIDGE_TIMEOUT_EN
            tmo_q   <= '0;
`endif
            if (beats_q == MAX_BURST_LOG'(1)) begin
              s_cyc_q <= 1'b0;
              s_stb_q <= 1'b0;
              state_q <= RESP;
            end
          end
`ifdef WB_BRIDGE_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
            m_err_q <= 1'b1;
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            beats_q <= '0;
            state_q <= RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end

        // One dead cycle so a strobe held across the final ack is not
        // mistaken for a new request.
        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_wb.cyc     = s_cyc_q;
  assign s_wb.stb     = s_stb_q;
  assign s_wb.adr     = s_adr_q;
  assign s_wb.o_dat   = s_dat_q;
  assign s_wb.we      = s_we_q;
  assign s_wb.sel     = s_sel_q;
  assign s_wb.burst_8 = s_b8_q;
  assign s_wb.burst_4 = s_b4_q;

  assign m_wb.ack     = m_ack_q;
  assign m_wb.err     = m_err_q;
  assign m_wb.i_dat   = m_dat_q;

endmodule
